// File: rtl/fc8_video_frame_checker.sv
// fc8_video_frame_checker
//   VGA output monitor. Samples hsync/vsync/rgb on pix_ce, measures line length and frame
//   height against H_TOTAL/V_TOTAL, and signs every frame's visible pixels with CRC-16-CCITT
//   (poly 0x1021, init 0xFFFF, MSB first).
// Ports
//   master_clk, master_rst_n : clock, async active-low reset
//   pix_ce                   : pixel-clock enable (one master_clk cycle per pixel)
//   enable                   : 1 = run, 0 = back to idle with latched results held
//   clear                    : synchronous clear of results, errors and frame counter
//   vga_hsync/vsync/rgb      : observed video
//   frame_done               : 1-cycle pulse when a frame's results are latched
//   frame_crc, frame_count   : last frame signature, number of complete frames
//   meas_h, meas_v           : last measured line length / frame height
//   h_err, v_err             : sticky timing errors
//   locked                   : two consecutive clean frames with equal CRC
//   nonblack_count           : non-zero visible pixels of the last frame
// Optional feature: define FC8_VCHK_NONBLACK_CNT_EN to build the non-black pixel counter;
// otherwise nonblack_count is tied to 0.
module fc8_video_frame_checker #(
   parameter int unsigned H_TOTAL         = 341,
   parameter int unsigned V_TOTAL         = 262,
   parameter int unsigned RGB_W           = 8,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter int unsigned FRAME_CNT_W     = 16
) (
   input  logic                   master_clk,
   input  logic                   master_rst_n,
   input  logic                   pix_ce,
   input  logic                   enable,
   input  logic                   clear,
   input  logic                   vga_hsync,
   input  logic                   vga_vsync,
   input  logic [RGB_W-1:0]       vga_rgb,
   output logic                   frame_done,
   output logic [15:0]            frame_crc,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic [15:0]            meas_h,
   output logic [15:0]            meas_v,
   output logic                   h_err,
   output logic                   v_err,
   output logic                   locked,
   output logic [23:0]            nonblack_count
);

   localparam logic [15:0] HTot = 16'(H_TOTAL);
   localparam logic [15:0] VTot = 16'(V_TOTAL);

   typedef enum logic [1:0] {StIdle, StSeek, StMeasure, StLocked} state_e;

   state_e      state_q;
   logic        h_act, v_act, h_act_q, v_act_q;
   logic        h_edge, v_edge, visible;
   logic [15:0] pix_cnt_q, line_cnt_q, crc_q;
   logic        h_armed_q;     // first hsync edge after SEEK ends a partial line
   logic        frame_herr_q;  // line-length error seen in the frame being measured
   logic [1:0]  good_cnt_q, good_d;
   logic        h_bad, frame_bad;

`ifdef FC8_VCHK_NONBLACK_CNT_EN
   logic [23:0] nb_cnt_q;
`else
   assign nonblack_count = 24'd0;
`endif

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [RGB_W-1:0] d);
      logic [15:0] r;
      r = c;
      for (int i = int'(RGB_W) - 1; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign h_act   = SYNC_ACTIVE_LOW ? ~vga_hsync : vga_hsync;
   assign v_act   = SYNC_ACTIVE_LOW ? ~vga_vsync : vga_vsync;
   assign h_edge  = pix_ce & h_act & ~h_act_q;
   assign v_edge  = pix_ce & v_act & ~v_act_q;
   assign visible = pix_ce & ~h_act & ~v_act;

   // The hsync edge coincident with a vsync edge closes the last line of the ending frame.
   assign h_bad     = h_edge & h_armed_q & (pix_cnt_q != HTot);
   assign frame_bad = frame_herr_q | h_bad | (line_cnt_q != VTot);

   // Good-frame streak: a clean frame starts it, a clean frame with a repeated CRC extends it.
   always_comb begin
      good_d = 2'd1;
      if (frame_bad)                good_d = 2'd0;
      else if (good_cnt_q == 2'd0)  good_d = 2'd1;
      else if (crc_q == frame_crc)  good_d = 2'd2;
   end

   always_ff @(posedge master_clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         state_q      <= StIdle;
         h_act_q      <= 1'b0;
         v_act_q      <= 1'b0;
         pix_cnt_q    <= 16'd0;
         line_cnt_q   <= 16'd0;
         crc_q        <= 16'hFFFF;
         h_armed_q    <= 1'b0;
         frame_herr_q <= 1'b0;
         good_cnt_q   <= 2'd0;
         frame_done   <= 1'b0;
         frame_crc    <= 16'd0;
         frame_count  <= '0;
         meas_h       <= 16'd0;
         meas_v       <= 16'd0;
         h_err        <= 1'b0;
         v_err        <= 1'b0;
         locked       <= 1'b0;
`ifdef FC8_VCHK_NONBLACK_CNT_EN
         nb_cnt_q       <= 24'd0;
         nonblack_count <= 24'd0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (pix_ce) begin
            h_act_q <= h_act;
            v_act_q <= v_act;
         end
         if (clear) begin
            frame_crc    <= 16'd0;
            frame_count  <= '0;
            meas_h       <= 16'd0;
            meas_v       <= 16'd0;
            h_err        <= 1'b0;
            v_err        <= 1'b0;
            locked       <= 1'b0;
            good_cnt_q   <= 2'd0;
            frame_herr_q <= 1'b0;
         end
         if (!enable) begin
            state_q      <= StIdle;
            locked       <= 1'b0;
            good_cnt_q   <= 2'd0;
            pix_cnt_q    <= 16'd0;
            line_cnt_q   <= 16'd0;
            crc_q        <= 16'hFFFF;
            h_armed_q    <= 1'b0;
            frame_herr_q <= 1'b0;
`ifdef FC8_VCHK_NONBLACK_CNT_EN
            nb_cnt_q     <= 24'd0;
`endif
         end else if (clear) begin
            // clear swallows a coincident pix_ce event
            if (state_q == StLocked)    state_q <= StMeasure;
            else if (state_q == StIdle) state_q <= StSeek;
         end else begin
            unique case (state_q)
               StIdle: state_q <= StSeek;
               StSeek: begin
                  if (v_edge) begin
                     state_q      <= StMeasure;
                     pix_cnt_q    <= {15'd0, h_edge};
                     line_cnt_q   <= {15'd0, h_edge};
                     crc_q        <= 16'hFFFF;
                     h_armed_q    <= 1'b0;
                     frame_herr_q <= 1'b0;
`ifdef FC8_VCHK_NONBLACK_CNT_EN
                     nb_cnt_q     <= 24'd0;
`endif
                  end
               end
               StMeasure, StLocked: begin
                  if (pix_ce) begin
                     if (h_edge) begin
                        meas_h    <= pix_cnt_q;
                        pix_cnt_q <= 16'd1;
                        h_armed_q <= 1'b1;
                        if (h_bad) begin
                           h_err        <= 1'b1;
                           frame_herr_q <= 1'b1;
                        end
                     end else if (pix_cnt_q != 16'hFFFF) begin
                        pix_cnt_q <= pix_cnt_q + 16'd1;
                     end
                     if (v_edge) begin
                        frame_crc    <= crc_q;
                        meas_v       <= line_cnt_q;
                        frame_count  <= frame_count + FRAME_CNT_W'(1);
                        if (line_cnt_q != VTot) v_err <= 1'b1;
                        frame_done   <= 1'b1;
                        good_cnt_q   <= good_d;
                        locked       <= (good_d == 2'd2);
                        state_q      <= (good_d == 2'd2) ? StLocked : StMeasure;
                        line_cnt_q   <= {15'd0, h_edge};
                        crc_q        <= 16'hFFFF;
                        frame_herr_q <= 1'b0;
`ifdef FC8_VCHK_NONBLACK_CNT_EN
                        nonblack_count <= nb_cnt_q;
                        nb_cnt_q       <= 24'd0;
`endif
                     end else begin
                        if (h_edge && line_cnt_q != 16'hFFFF) line_cnt_q <= line_cnt_q + 16'd1;
                        if (visible) begin
                           crc_q <= crc_step(crc_q, vga_rgb);
`ifdef FC8_VCHK_NONBLACK_CNT_EN
                           if (vga_rgb != '0 && nb_cnt_q != 24'hFFFFFF) nb_cnt_q <= nb_cnt_q + 24'd1;
`endif
                        end
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
